// File: rtl/sp_pkg.sv
// Processor-wide bus widths plus the types shared by the memory responder.
// The port-state enum is the debug view of each responder port FSM.
package sp_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MP_IDLE = 2'd0,
        MP_BUSY = 2'd1,
        MP_ACK  = 2'd2
    } mem_port_state_e;

    // Number of byte-offset bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/sp_mem_port_ctrl.sv
// One responder port: IDLE -> BUSY -> ACK FSM, latency counter and capture registers.
// The *_next outputs give the values the port will hold after the coming edge.
module sp_mem_port_ctrl #(
    parameter int ADDR_WIDTH = sp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sp_pkg::DATA_WIDTH,
    parameter int IDX_W      = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  fire,
    output logic                  fire_next,
    output logic [IDX_W-1:0]      idx,
    output logic [IDX_W-1:0]      idx_next,
    output logic                  wr,
    output logic                  wr_next,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [1:0]            state
);
    import sp_pkg::*;

    localparam int               ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = MP_IDLE;
    localparam logic [1:0] ST_BUSY = MP_BUSY;
    localparam logic [1:0] ST_ACK  = MP_ACK;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  capture;

    // Inputs are only looked at in IDLE; afterwards the captured copies rule.
    assign capture = (state_q == ST_IDLE) && req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? ST_ACK : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (rst_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= addr_i[ADDR_LSB +: IDX_W];
                wr_q    <= wr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign fire      = (state_q == ST_ACK);
    assign fire_next = (state_d == ST_ACK);
    assign idx       = idx_q;
    assign idx_next  = capture ? addr_i[ADDR_LSB +: IDX_W] : idx_q;
    assign wr        = wr_q;
    assign wr_next   = capture ? wr_i : wr_q;
    assign wdata     = wdata_q;
    assign state     = state_q;

endmodule

// File: rtl/sp_mem_responder.sv
// Backing memory for the imem/dmem req/ack ports: one shared word array,
// per-port latency, registered ack and rdata.
//
// Handshake: the initiator raises req with address (and wr/wdata) and holds
// it until ack; ack is a single-cycle pulse that completes the transfer and
// rdata is meaningful only while ack is high (zero otherwise). A req still
// high in the cycle after ack starts a new transfer.
module sp_mem_responder #(
    parameter int ADDR_WIDTH   = sp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = sp_pkg::DATA_WIDTH,
    parameter int DEPTH        = 1024,
    parameter int IMEM_LATENCY = 1,
    parameter int DMEM_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_wr_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o
);
    import sp_pkg::*;

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W    = $clog2(DEPTH);

    if (IMEM_LATENCY < 1 || DMEM_LATENCY < 1) begin : g_bad_latency
        $error("sp_mem_responder: IMEM_LATENCY and DMEM_LATENCY must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sp_mem_responder: DEPTH must be a power of 2 and >= 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sp_mem_responder: DATA_WIDTH must be a multiple of 8");
    end
    if (IDX_W + ADDR_LSB > ADDR_WIDTH) begin : g_bad_addr
        $error("sp_mem_responder: DEPTH does not fit in ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  i_fire, i_fire_next, i_wr, i_wr_next;
    logic [IDX_W-1:0]      i_idx, i_idx_next;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [1:0]            i_state;

    logic                  d_fire, d_fire_next, d_wr, d_wr_next;
    logic [IDX_W-1:0]      d_idx, d_idx_next;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [1:0]            d_state;

    logic [DATA_WIDTH-1:0] imem_word;
    logic                  unused_ok;

    sp_mem_port_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W),
        .LATENCY   (IMEM_LATENCY)
    ) u_imem_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (imem_req_i),
        .wr_i     (1'b0),
        .addr_i   (imem_addr_i),
        .wdata_i  ('0),
        .fire     (i_fire),
        .fire_next(i_fire_next),
        .idx      (i_idx),
        .idx_next (i_idx_next),
        .wr       (i_wr),
        .wr_next  (i_wr_next),
        .wdata    (i_wdata),
        .state    (i_state)
    );

    sp_mem_port_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W),
        .LATENCY   (DMEM_LATENCY)
    ) u_dmem_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (dmem_req_i),
        .wr_i     (dmem_wr_i),
        .addr_i   (dmem_addr_i),
        .wdata_i  (dmem_wdata_i),
        .fire     (d_fire),
        .fire_next(d_fire_next),
        .idx      (d_idx),
        .idx_next (d_idx_next),
        .wr       (d_wr),
        .wr_next  (d_wr_next),
        .wdata    (d_wdata),
        .state    (d_state)
    );

    // Read data is registered on the edge that enters ACK, so a dmem write
    // committing on that same edge must be forwarded to imem.
    always_comb begin
        imem_word = mem[i_idx_next];
        if (d_fire && d_wr && (d_idx == i_idx_next)) imem_word = d_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem_ack_o   <= 1'b0;
            imem_rdata_o <= '0;
            dmem_ack_o   <= 1'b0;
            dmem_rdata_o <= '0;
        end else begin
            imem_ack_o   <= i_fire_next;
            imem_rdata_o <= i_fire_next ? imem_word : '0;
            dmem_ack_o   <= d_fire_next;
            // dmem never enters ACK straight from ACK, so its own write needs no bypass.
            dmem_rdata_o <= (d_fire_next && !d_wr_next) ? mem[d_idx_next] : '0;
        end
    end

    // Array is never cleared; reset only suppresses an in-flight commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && d_fire && d_wr) mem[d_idx] <= d_wdata;
    end

    assign unused_ok = ^{i_fire, i_idx, i_wr, i_wr_next, i_wdata, i_state, d_state};

endmodule

// File: tb/tb_sp_mem_responder.sv
// Bench for sp_mem_responder: two instances (default latencies and 3/1),
// a transaction-level model compared every cycle, plus directed literal checks.
module tb_sp_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          imem_req   [2];
    logic [AW-1:0] imem_addr  [2];
    logic [DW-1:0] imem_rdata [2];
    logic          imem_ack   [2];
    logic          dmem_req   [2];
    logic          dmem_wr    [2];
    logic [AW-1:0] dmem_addr  [2];
    logic [DW-1:0] dmem_wdata [2];
    logic [DW-1:0] dmem_rdata [2];
    logic          dmem_ack   [2];

    int checks   = 0;
    int failures = 0;

    sp_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .IMEM_LATENCY(1), .DMEM_LATENCY(2)
    ) dut0 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(imem_req[0]), .imem_addr_i(imem_addr[0]),
        .imem_rdata_o(imem_rdata[0]), .imem_ack_o(imem_ack[0]),
        .dmem_req_i(dmem_req[0]), .dmem_wr_i(dmem_wr[0]),
        .dmem_addr_i(dmem_addr[0]), .dmem_wdata_i(dmem_wdata[0]),
        .dmem_rdata_o(dmem_rdata[0]), .dmem_ack_o(dmem_ack[0])
    );

    sp_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .IMEM_LATENCY(3), .DMEM_LATENCY(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(imem_req[1]), .imem_addr_i(imem_addr[1]),
        .imem_rdata_o(imem_rdata[1]), .imem_ack_o(imem_ack[1]),
        .dmem_req_i(dmem_req[1]), .dmem_wr_i(dmem_wr[1]),
        .dmem_addr_i(dmem_addr[1]), .dmem_wdata_i(dmem_wdata[1]),
        .dmem_rdata_o(dmem_rdata[1]), .dmem_ack_o(dmem_ack[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    // A transfer captured at edge e acks in the cycle after edge e+L-1; its
    // write lands at edge e+L, and the port accepts again at edge e+L+1.
    int            edge_n = 0;
    bit            m_busy     [2][2];   // [dut][port]; port 0 = imem, 1 = dmem
    bit            m_retired  [2][2];
    int            m_ack_edge [2][2];
    int            m_key      [2][2];
    bit            m_wr       [2][2];
    logic [31:0]   m_wdata    [2][2];
    bit            m_exp_ack  [2][2];
    bit            m_known    [2][2];
    logic [31:0]   m_exp_data [2][2];
    logic [31:0]   mdl_mem    [int];

    function automatic int port_lat(input int k, input int p);
        if (k == 0) return (p == 0) ? 1 : 2;
        return (p == 0) ? 3 : 1;
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                m_retired[k][p] = 1'b0;
                if (rst) begin
                    m_busy[k][p] = 1'b0;
                end else if (m_busy[k][p] && edge_n == m_ack_edge[k][p] + 1) begin
                    if (m_wr[k][p]) mdl_mem[m_key[k][p]] = m_wdata[k][p];
                    m_busy[k][p]    = 1'b0;
                    m_retired[k][p] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic        req;
                logic [31:0] addr;
                req  = (p == 0) ? imem_req[k] : dmem_req[k];
                addr = (p == 0) ? imem_addr[k] : dmem_addr[k];
                if (!rst && !m_busy[k][p] && !m_retired[k][p] && req) begin
                    m_busy[k][p]     = 1'b1;
                    m_ack_edge[k][p] = edge_n + port_lat(k, p) - 1;
                    m_key[k][p]      = k * DEPTH + int'((addr / 4) % DEPTH);
                    m_wr[k][p]       = (p == 1) ? dmem_wr[k] : 1'b0;
                    m_wdata[k][p]    = dmem_wdata[k];
                end
                m_exp_ack[k][p] = !rst && m_busy[k][p] && (edge_n == m_ack_edge[k][p]);
                m_known[k][p]   = 1'b1;
                m_exp_data[k][p] = '0;
                if (m_exp_ack[k][p] && !m_wr[k][p]) begin
                    m_known[k][p] = mdl_mem.exists(m_key[k][p]);
                    if (m_known[k][p]) m_exp_data[k][p] = mdl_mem[m_key[k][p]];
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                string pn;
                pn = (p == 0) ? "imem" : "dmem";
                chk($sformatf("mdl_%s_ack_d%0d", pn, k),
                    {31'd0, (p == 0) ? imem_ack[k] : dmem_ack[k]}, {31'd0, m_exp_ack[k][p]});
                if (m_known[k][p])
                    chk($sformatf("mdl_%s_rdata_d%0d", pn, k),
                        (p == 0) ? imem_rdata[k] : dmem_rdata[k], m_exp_data[k][p]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic dmem_xfer(input int k, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit toggle,
                             output logic [31:0] rdata, output int lat);
        @(negedge clk);
        dmem_req[k] = 1'b1; dmem_wr[k] = wr; dmem_addr[k] = addr; dmem_wdata[k] = wdata;
        lat = 0; rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #2;
            if (dmem_ack[k]) begin
                lat = c; rdata = dmem_rdata[k];
                break;
            end
            if (toggle) begin
                dmem_addr[k] = addr ^ 32'h4; dmem_wdata[k] = ~wdata; dmem_wr[k] = ~wr;
            end
        end
        @(negedge clk);
        dmem_req[k] = 1'b0;
    endtask

    task automatic imem_xfer(input int k, input logic [31:0] addr, input bit toggle,
                             output logic [31:0] rdata, output int lat);
        @(negedge clk);
        imem_req[k] = 1'b1; imem_addr[k] = addr;
        lat = 0; rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #2;
            if (imem_ack[k]) begin
                lat = c; rdata = imem_rdata[k];
                break;
            end
            if (toggle) imem_addr[k] = addr ^ 32'h4;
        end
        @(negedge clk);
        imem_req[k] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        logic [5:0]  ack_vec;
        int          ack_cnt;

        for (int k = 0; k < 2; k++) begin
            imem_req[k] = 0; imem_addr[k] = '0;
            dmem_req[k] = 0; dmem_wr[k] = 0; dmem_addr[k] = '0; dmem_wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_imem_ack", {31'd0, imem_ack[k]}, 32'd0);
            chk("rst_dmem_ack", {31'd0, dmem_ack[k]}, 32'd0);
            chk("rst_imem_rdata", imem_rdata[k], 32'd0);
            chk("rst_dmem_rdata", dmem_rdata[k], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        dmem_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, lat);
        chk("wr10_lat", lat, 2);
        chk("wr10_rdata", rd, 32'd0);
        dmem_xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
        chk("rd10_lat", lat, 2);
        chk("rd10_rdata", rd, 32'hDEADBEEF);

        // imem request held high: one ack every other cycle
        @(negedge clk);
        imem_req[0] = 1'b1; imem_addr[0] = 32'h10;
        ack_vec = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2;
            ack_vec[c] = imem_ack[0];
            if (imem_ack[0]) chk("hold_rdata", imem_rdata[0], 32'hDEADBEEF);
            else             chk("hold_rdata_idle", imem_rdata[0], 32'd0);
        end
        @(negedge clk);
        imem_req[0] = 1'b0;
        chk("hold_ack_pattern", {26'd0, ack_vec}, 32'h15);

        // collision: dmem write ack coincides with imem read ack
        dmem_xfer(0, 1'b1, 32'h20, 32'h5, 1'b0, rd, lat);
        @(negedge clk);
        dmem_req[0] = 1'b1; dmem_wr[0] = 1'b1; dmem_addr[0] = 32'h20; dmem_wdata[0] = 32'h1;
        @(negedge clk);
        imem_req[0] = 1'b1; imem_addr[0] = 32'h20;
        @(posedge clk); #2;
        chk("coll_dmem_ack", {31'd0, dmem_ack[0]}, 32'd1);
        chk("coll_imem_ack", {31'd0, imem_ack[0]}, 32'd1);
        chk("coll_imem_old", imem_rdata[0], 32'h5);
        @(negedge clk);
        imem_req[0] = 1'b0; dmem_req[0] = 1'b0;
        imem_xfer(0, 32'h20, 1'b0, rd, lat);
        chk("coll_imem_lat", lat, 1);
        chk("coll_imem_new", rd, 32'h1);

        // aliasing: sub-word and upper address bits ignored
        dmem_xfer(0, 1'b1, 32'h13, 32'hA5A51234, 1'b0, rd, lat);
        dmem_xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
        chk("alias_10", rd, 32'hA5A51234);
        dmem_xfer(0, 1'b0, 32'h1010, 32'h0, 1'b0, rd, lat);
        chk("alias_1010", rd, 32'hA5A51234);

        // reset in the BUSY cycle of a write aborts it
        dmem_xfer(0, 1'b1, 32'h30, 32'h7, 1'b0, rd, lat);
        @(negedge clk);
        dmem_req[0] = 1'b1; dmem_wr[0] = 1'b1; dmem_addr[0] = 32'h30; dmem_wdata[0] = 32'h99;
        @(negedge clk);
        rst = 1'b1; dmem_req[0] = 1'b0;
        ack_cnt = 0;
        @(posedge clk); #2;
        ack_cnt += int'(dmem_ack[0]);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            ack_cnt += int'(dmem_ack[0]);
        end
        chk("rst_abort_ack", ack_cnt, 0);
        dmem_xfer(0, 1'b0, 32'h30, 32'h0, 1'b0, rd, lat);
        chk("rst_abort_keep", rd, 32'h7);

        // req dropped before ack: the write still completes
        @(negedge clk);
        dmem_req[0] = 1'b1; dmem_wr[0] = 1'b1; dmem_addr[0] = 32'h60; dmem_wdata[0] = 32'h77;
        @(negedge clk);
        dmem_req[0] = 1'b0;
        repeat (4) @(negedge clk);
        dmem_xfer(0, 1'b0, 32'h60, 32'h0, 1'b0, rd, lat);
        chk("drop_req_commit", rd, 32'h77);

        // inputs toggled during BUSY: captured values win
        dmem_xfer(0, 1'b1, 32'h50, 32'h3333, 1'b1, rd, lat);
        chk("tog_wr_lat", lat, 2);
        dmem_xfer(0, 1'b0, 32'h50, 32'h0, 1'b0, rd, lat);
        chk("tog_wr_data", rd, 32'h3333);

        // latency sweep on the second instance (imem 3, dmem 1)
        dmem_xfer(1, 1'b1, 32'h40, 32'h1111, 1'b1, rd, lat);
        chk("sweep_dwr_lat", lat, 1);
        chk("sweep_dwr_rdata", rd, 32'd0);
        dmem_xfer(1, 1'b1, 32'h44, 32'h2222, 1'b0, rd, lat);
        imem_xfer(1, 32'h40, 1'b1, rd, lat);
        chk("sweep_imem_lat", lat, 3);
        chk("sweep_imem_capt", rd, 32'h1111);
        dmem_xfer(1, 1'b0, 32'h44, 32'h0, 1'b0, rd, lat);
        chk("sweep_drd_lat", lat, 1);
        chk("sweep_drd_data", rd, 32'h2222);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
